mdu_sequencer: RTL and testbench

Iterative multiply/divide sequencer for the RV32M extension in the execute stage. It accepts one M-extension operation per request and runs a 32-step shift-add multiply or restoring divide. It stalls the pipeline while the operation is in progress and delivers the 32-bit result with a single-cycle done pulse. The decoder raises `start` when the EX instruction has ALUOp=10 and Funct7=0000001.

---
 rtl/mdu_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply and restoring divide
// on operand magnitudes, with signs applied in a final fix-up step.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastStep = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StMulIter,
    StDivIter,
    StFix,
    StDone
  } state_e;

  state_e             state;
  logic [2:0]         op;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  // Multiplier shifting right (multiply) or dividend-in / quotient-out shifting left (divide)
  logic [WIDTH-1:0]   work;
  logic [CW-1:0]      cnt;

  logic               a_signed;
  logic               b_signed;
  logic               pa;
  logic               pb;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic               div_by_zero;
  logic               div_ovf;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_val;

  // Signed A: MUL/MULH/MULHSU/DIV/REM; signed B: MULH/DIV/REM
  assign a_signed = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
  assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign pa       = a_signed & opa[WIDTH-1];
  assign pb       = b_signed & opb[WIDTH-1];
  assign mag_a_in = pa ? -opa : opa;
  assign mag_b_in = pb ? -opb : opb;

  assign div_by_zero = op[2] && (opb == '0);
  assign div_ovf     = op[2] && !op[0] && (opa == MinNeg) && (opb == '1);

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, mag_a} : '0);

  // Shifted partial remainder is WIDTH+1 bits wide; after restoring it fits in WIDTH bits
  assign trial = {rem, work[WIDTH-1]};
  assign q_bit = trial >= {1'b0, mag_b};
  assign diff  = trial - {1'b0, mag_b};

  assign prod    = (sign_a ^ sign_b) ? -acc : acc;
  assign quo_fix = (sign_a ^ sign_b) ? -work : work;
  assign rem_fix = sign_a ? -rem : rem;

  always_comb begin
    fix_val = quo_fix;
    if (!op[2]) begin
      fix_val = (op[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end else if (op[1]) begin
      fix_val = rem_fix;
    end
  end

  assign stall = (state == StIdle) ? (start && !flush) : ((state != StDone) && !flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= StIdle;
      op     <= '0;
      opa    <= '0;
      opb    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      rem    <= '0;
      work   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Result <= '0;
    end else if (flush && (state != StIdle)) begin
      state <= StIdle;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          done <= 1'b0;
          if (start && !flush) begin
            op    <= Funct3;
            opa   <= SrcA;
            opb   <= SrcB;
            busy  <= 1'b1;
            state <= StPrep;
          end
        end
        StPrep: begin
          sign_a <= pa;
          sign_b <= pb;
          mag_a  <= mag_a_in;
          mag_b  <= mag_b_in;
          acc    <= '0;
          rem    <= '0;
          cnt    <= '0;
          work   <= op[2] ? mag_a_in : mag_b_in;
          if (div_by_zero) begin
            Result <= op[1] ? opa : '1;
            done   <= 1'b1;
            state  <= StDone;
          end else if (div_ovf) begin
            Result <= op[1] ? '0 : MinNeg;
            done   <= 1'b1;
            state  <= StDone;
          end else begin
            state <= op[2] ? StDivIter : StMulIter;
          end
        end
        StMulIter: begin
          acc  <= {mul_sum, acc[WIDTH-1:1]};
          work <= work >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == LastStep) state <= StFix;
        end
        StDivIter: begin
          rem  <= q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
          work <= {work[WIDTH-2:0], q_bit};
          cnt  <= cnt + 1'b1;
          if (cnt == LastStep) state <= StFix;
        end
        StFix: begin
          Result <= fix_val;
          done   <= 1'b1;
          state  <= StDone;
        end
        StDone: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized and directed bench for mdu_sequencer against an arithmetic RV32M reference model.
module tb_mdu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  Funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  int          n_checks;
  int          n_pass;
  logic [31:0] last_res;

  mdu_sequencer #(
    .WIDTH(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Funct3(Funct3),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .flush (flush),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .Result(Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    int          sa;
    int          sb;
    ea = ((f3 == 3'd1) || (f3 == 3'd2)) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Called at a falling edge with the DUT idle; returns one cycle after DONE, still idle.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int poke);
    logic [31:0] exp_res;
    logic        special;
    int          exp_cyc;
    int          done_cyc;
    int          stall_cnt;
    exp_res  = ref_mdu(f3, a, b);
    special  = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_cyc  = special ? 2 : 35;
    Funct3   = f3;
    SrcA     = a;
    SrcB     = b;
    start    = 1'b1;
    #1;
    stall_cnt = stall ? 1 : 0;
    done_cyc  = 0;
    for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      start  = (cyc == poke);
      SrcA   = $urandom;
      SrcB   = $urandom;
      Funct3 = 3'($urandom);
      #1;
      if (stall) stall_cnt++;
      if (done) done_cyc = cyc;
    end
    check($sformatf("latency f3=%0d a=%h b=%h", f3, a, b), done_cyc, exp_cyc);
    check($sformatf("result f3=%0d a=%h b=%h", f3, a, b), Result, exp_res);
    check($sformatf("stall_cycles f3=%0d", f3), stall_cnt, exp_cyc);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("done_single_pulse", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    check("result_holds", Result, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    int done_seen;
    n_checks = 0;
    n_pass   = 0;
    last_res = 32'h0;
    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    Funct3   = 3'd0;
    SrcA     = 32'h0;
    SrcB     = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", Result, 32'h0);
    check("reset_stall", stall, 1'b0);

    // Directed vectors, back to back
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd5, 32'd100, 32'd7, 0);
    do_op(3'd7, 32'd100, 32'd7, 5);
    do_op(3'd5, 32'd5, 32'd0, 0);
    do_op(3'd6, 32'd5, 32'd0, 1);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Flush at iteration 10
    Funct3 = 3'd0;
    SrcA   = 32'd5;
    SrcB   = 32'd6;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall_low", stall, 1'b0);
    check("flush_busy_before", busy, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy", busy, 1'b0);
    check("flush_done", done, 1'b0);
    check("flush_result_kept", Result, last_res);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("flush_no_done", done_seen, 0);
    #1;
    do_op(3'd0, 32'd3, 32'd4, 0);

    // start and flush together in IDLE
    start = 1'b1;
    flush = 1'b1;
    #1;
    check("start_flush_stall", stall, 1'b0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    #1;
    check("start_flush_busy", busy, 1'b0);
    @(negedge clk);
    #1;
    check("start_flush_busy2", busy, 1'b0);

    // Reset at iteration 20
    Funct3 = 3'd0;
    SrcA   = 32'd9;
    SrcB   = 32'd9;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_result", Result, 32'h0);
    check("rst_mid_stall", stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("rst_no_done", done_seen, 0);
    #1;
    check("rst_busy_after", busy, 1'b0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 3) == 0) ? 7 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
